// File: rtl/acq_seq_pkg.sv
// Shared types and constants for the lidar pulse acquisition sequencer.
package acq_seq_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PROD_W = 2 * CNT_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DUMP    = 2'd3
   } acq_state_e;

   typedef struct packed {
      logic [CNT_W-1:0] n_total;
      logic [CNT_W-1:0] n_rb;
      logic [CNT_W-1:0] n_pts_rb;
      logic [CNT_W-1:0] n_acc;
   } acq_cfg_t;

   // Product kept at double width so large bin geometries cannot wrap into range.
   function automatic logic cfg_valid(input acq_cfg_t cfg);
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(cfg.n_rb) * PROD_W'(cfg.n_pts_rb);
      return (cfg.n_rb != '0) && (cfg.n_pts_rb != '0) && (cfg.n_acc != '0) &&
             (prod <= PROD_W'(cfg.n_total));
   endfunction

endpackage

// File: rtl/acq_bin_counter.sv
// Nested point-in-bin / bin counters; tags each capture cycle with its range-bin position.
module acq_bin_counter
   import acq_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] n_rb_i,
   input  logic [CNT_W-1:0] n_pts_rb_i,
   output logic             rb_valid_o,
   output logic             rb_first_o,
   output logic             rb_last_o,
   output logic [CNT_W-1:0] rb_idx_o
);

   logic [CNT_W-1:0] r_pt;
   logic [CNT_W-1:0] r_bin;
   logic             r_valid;
   logic             r_first;
   logic             r_last;

   logic [CNT_W-1:0] w_pt_nxt;
   logic [CNT_W-1:0] w_bin_nxt;
   logic [CNT_W-1:0] w_pt_inc;
   logic             w_valid_nxt;
   logic             w_first_nxt;
   logic             w_last_nxt;
   logic             w_single;

   assign w_single = (n_pts_rb_i == CNT_W'(1));
   assign w_pt_inc = r_pt + CNT_W'(1);

   // Anything other than start or an in-window advance clears the tags.
   always_comb begin
      w_pt_nxt    = '0;
      w_bin_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_first_nxt = 1'b0;
      w_last_nxt  = 1'b0;
      if (start_i) begin
         w_valid_nxt = 1'b1;
         w_first_nxt = 1'b1;
         w_last_nxt  = w_single;
      end else if (enable_i && r_valid) begin
         if (w_pt_inc == n_pts_rb_i) begin
            if (r_bin != n_rb_i - CNT_W'(1)) begin
               w_bin_nxt   = r_bin + CNT_W'(1);
               w_valid_nxt = 1'b1;
               w_first_nxt = 1'b1;
               w_last_nxt  = w_single;
            end
         end else begin
            w_pt_nxt    = w_pt_inc;
            w_bin_nxt   = r_bin;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (w_pt_inc == n_pts_rb_i - CNT_W'(1));
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pt    <= '0;
         r_bin   <= '0;
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_pt    <= w_pt_nxt;
         r_bin   <= w_bin_nxt;
         r_valid <= w_valid_nxt;
         r_first <= w_first_nxt;
         r_last  <= w_last_nxt;
      end
   end

   assign rb_valid_o = r_valid;
   assign rb_first_o = r_first;
   assign rb_last_o  = r_last;
   assign rb_idx_o   = r_bin;

endmodule

// File: rtl/pulse_acq_sequencer.sv
// Lidar acquisition sequencer: arm, per-trigger capture window, pulse accumulation, spectrum dump.
// Missed-trigger counter is built only when ACQ_MISSED_TRIG_CNT_EN is defined.
module pulse_acq_sequencer
   import acq_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_en_i,
   input  logic             trig_i,
   input  logic [CNT_W-1:0] n_total_i,
   input  logic [CNT_W-1:0] n_rb_i,
   input  logic [CNT_W-1:0] n_pts_rb_i,
   input  logic [CNT_W-1:0] n_acc_i,
   input  logic             dump_done_i,
   output logic             sample_valid_o,
   output logic             rb_valid_o,
   output logic             rb_first_o,
   output logic             rb_last_o,
   output logic [CNT_W-1:0] rb_idx_o,
   output logic [CNT_W-1:0] pulse_idx_o,
   output logic             acc_first_o,
   output logic             acc_last_o,
   output logic             dump_req_o,
   output logic             busy_o,
   output logic             cfg_err_o,
   output logic [CNT_W-1:0] missed_trig_o
);

   acq_state_e       r_state;
   acq_state_e       w_state_nxt;
   acq_cfg_t         r_cfg;
   acq_cfg_t         w_cfg_nxt;
   acq_cfg_t         w_cfg_in;
   logic [CNT_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] w_win_cnt_nxt;
   logic [CNT_W-1:0] r_pulse_idx;
   logic [CNT_W-1:0] w_pulse_idx_nxt;
   logic             r_trig_d;
   logic             r_cfg_err;
   logic             w_cfg_err_nxt;
   logic             r_sample_valid;
   logic             r_acc_first;
   logic             r_acc_last;
   logic             r_dump_req;
   logic             r_busy;
   logic             w_sample_valid_nxt;
   logic             w_acc_first_nxt;
   logic             w_acc_last_nxt;
   logic             w_dump_req_nxt;
   logic             w_busy_nxt;
   logic             w_trig_rise;
   logic             w_bin_start;
   logic             w_bin_enable;

   assign w_cfg_in    = '{n_total: n_total_i, n_rb: n_rb_i, n_pts_rb: n_pts_rb_i, n_acc: n_acc_i};
   assign w_trig_rise = trig_i & ~r_trig_d;

   // Next state and next registered outputs; a low cmd_en_i overrides every state.
   always_comb begin
      w_state_nxt     = r_state;
      w_cfg_nxt       = r_cfg;
      w_win_cnt_nxt   = r_win_cnt;
      w_pulse_idx_nxt = r_pulse_idx;
      w_cfg_err_nxt   = r_cfg_err;
      if (!cmd_en_i) begin
         w_state_nxt     = ST_IDLE;
         w_win_cnt_nxt   = '0;
         w_pulse_idx_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cfg_valid(w_cfg_in)) begin
                  w_state_nxt   = ST_ARMED;
                  w_cfg_nxt     = w_cfg_in;
                  w_cfg_err_nxt = 1'b0;
               end else begin
                  w_cfg_err_nxt = 1'b1;
               end
            end
            ST_ARMED: begin
               if (w_trig_rise) begin
                  w_state_nxt   = ST_CAPTURE;
                  w_win_cnt_nxt = CNT_W'(1);
               end
            end
            ST_CAPTURE: begin
               if (r_win_cnt == r_cfg.n_total) begin
                  w_win_cnt_nxt = '0;
                  if (r_pulse_idx < r_cfg.n_acc - CNT_W'(1)) begin
                     w_pulse_idx_nxt = r_pulse_idx + CNT_W'(1);
                     w_state_nxt     = ST_ARMED;
                  end else begin
                     w_state_nxt = ST_DUMP;
                  end
               end else begin
                  w_win_cnt_nxt = r_win_cnt + CNT_W'(1);
               end
            end
            ST_DUMP: begin
               if (dump_done_i) begin
                  w_pulse_idx_nxt = '0;
                  w_state_nxt     = ST_ARMED;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end

      w_sample_valid_nxt = (w_state_nxt == ST_CAPTURE);
      w_acc_first_nxt    = w_sample_valid_nxt && (w_pulse_idx_nxt == '0);
      w_acc_last_nxt     = w_sample_valid_nxt && (w_pulse_idx_nxt == w_cfg_nxt.n_acc - CNT_W'(1));
      w_dump_req_nxt     = (w_state_nxt == ST_DUMP);
      w_busy_nxt         = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state        <= ST_IDLE;
         r_cfg          <= '0;
         r_win_cnt      <= '0;
         r_pulse_idx    <= '0;
         r_trig_d       <= 1'b0;
         r_cfg_err      <= 1'b0;
         r_sample_valid <= 1'b0;
         r_acc_first    <= 1'b0;
         r_acc_last     <= 1'b0;
         r_dump_req     <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cfg          <= w_cfg_nxt;
         r_win_cnt      <= w_win_cnt_nxt;
         r_pulse_idx    <= w_pulse_idx_nxt;
         r_trig_d       <= trig_i;
         r_cfg_err      <= w_cfg_err_nxt;
         r_sample_valid <= w_sample_valid_nxt;
         r_acc_first    <= w_acc_first_nxt;
         r_acc_last     <= w_acc_last_nxt;
         r_dump_req     <= w_dump_req_nxt;
         r_busy         <= w_busy_nxt;
      end
   end

   assign w_bin_start  = (r_state == ST_ARMED)   && (w_state_nxt == ST_CAPTURE);
   assign w_bin_enable = (r_state == ST_CAPTURE) && (w_state_nxt == ST_CAPTURE);

   acq_bin_counter u_bin_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (w_bin_start),
      .enable_i   (w_bin_enable),
      .n_rb_i     (r_cfg.n_rb),
      .n_pts_rb_i (r_cfg.n_pts_rb),
      .rb_valid_o (rb_valid_o),
      .rb_first_o (rb_first_o),
      .rb_last_o  (rb_last_o),
      .rb_idx_o   (rb_idx_o)
   );

`ifdef ACQ_MISSED_TRIG_CNT_EN
   logic [CNT_W-1:0] r_missed;
   logic             w_missed_inc;

   // Edges that land while a window or dump is in progress; saturates at all-ones.
   assign w_missed_inc = w_trig_rise && ((r_state == ST_CAPTURE) || (r_state == ST_DUMP));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_missed <= '0;
      end else if (w_missed_inc && (r_missed != '1)) begin
         r_missed <= r_missed + CNT_W'(1);
      end
   end

   assign missed_trig_o = r_missed;
`else
   assign missed_trig_o = '0;
`endif

   assign sample_valid_o = r_sample_valid;
   assign pulse_idx_o    = r_pulse_idx;
   assign acc_first_o    = r_acc_first;
   assign acc_last_o     = r_acc_last;
   assign dump_req_o     = r_dump_req;
   assign busy_o         = r_busy;
   assign cfg_err_o      = r_cfg_err;

endmodule

// File: tb/tb_pulse_acq_sequencer.sv
// Self-checking bench for pulse_acq_sequencer against a cycle-level behavioural model.
module tb_pulse_acq_sequencer;
   import acq_seq_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_en = 1'b0;
   logic             trig = 1'b0;
   logic             dump_done = 1'b0;
   logic [CNT_W-1:0] n_total = '0;
   logic [CNT_W-1:0] n_rb = '0;
   logic [CNT_W-1:0] n_pts = '0;
   logic [CNT_W-1:0] n_acc = '0;

   logic             sample_valid, rb_valid, rb_first, rb_last, acc_first, acc_last;
   logic             dump_req, busy, cfg_err;
   logic [CNT_W-1:0] rb_idx, pulse_idx, missed;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   pulse_acq_sequencer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cmd_en_i       (cmd_en),
      .trig_i         (trig),
      .n_total_i      (n_total),
      .n_rb_i         (n_rb),
      .n_pts_rb_i     (n_pts),
      .n_acc_i        (n_acc),
      .dump_done_i    (dump_done),
      .sample_valid_o (sample_valid),
      .rb_valid_o     (rb_valid),
      .rb_first_o     (rb_first),
      .rb_last_o      (rb_last),
      .rb_idx_o       (rb_idx),
      .pulse_idx_o    (pulse_idx),
      .acc_first_o    (acc_first),
      .acc_last_o     (acc_last),
      .dump_req_o     (dump_req),
      .busy_o         (busy),
      .cfg_err_o      (cfg_err),
      .missed_trig_o  (missed)
   );

   wire [55:0] act_vec = {sample_valid, rb_valid, rb_first, rb_last, rb_idx, pulse_idx,
                          acc_first, acc_last, dump_req, busy, cfg_err, missed};

   // Reference model: mode 0 idle, 1 waiting for trigger, 2 in window, 3 dumping.
   // Bin tags are derived arithmetically from the offset into the window.
   int         m_mode = 0, m_off = 0, m_pulse = 0, m_missed = 0;
   int         c_tot = 1, c_rb = 1, c_pts = 1, c_acc = 1;
   bit         m_prev = 0, m_err = 0, rise, sv, bv;
   logic [55:0] exp_vec;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_mode = 0; m_off = 0; m_pulse = 0; m_missed = 0; m_prev = 0; m_err = 0;
      end else begin
         rise   = trig && !m_prev;
         m_prev = trig;
`ifdef ACQ_MISSED_TRIG_CNT_EN
         if (rise && (m_mode == 2 || m_mode == 3) && m_missed < 65535) m_missed++;
`endif
         if (!cmd_en) begin
            m_mode = 0; m_pulse = 0;
         end else if (m_mode == 0) begin
            if (n_rb != 0 && n_pts != 0 && n_acc != 0 &&
                longint'(n_rb) * longint'(n_pts) <= longint'(n_total)) begin
               c_tot = int'(n_total); c_rb = int'(n_rb); c_pts = int'(n_pts); c_acc = int'(n_acc);
               m_err = 0; m_mode = 1;
            end else m_err = 1;
         end else if (m_mode == 1) begin
            if (rise) begin m_mode = 2; m_off = 0; end
         end else if (m_mode == 2) begin
            if (m_off == c_tot - 1) begin
               if (m_pulse < c_acc - 1) begin m_pulse++; m_mode = 1; end
               else m_mode = 3;
            end else m_off++;
         end else if (dump_done) begin
            m_pulse = 0; m_mode = 1;
         end
      end
      sv = (m_mode == 2);
      bv = sv && (m_off < c_rb * c_pts);
      exp_vec = {sv, bv, bv && (m_off % c_pts == 0), bv && (m_off % c_pts == c_pts - 1),
                 16'(bv ? m_off / c_pts : 0), 16'(m_pulse),
                 sv && (m_pulse == 0), sv && (m_pulse == c_acc - 1),
                 m_mode == 3, m_mode != 0, m_err, 16'(m_missed)};
   end

   task automatic test_reset();
      rst = 1; cmd_en = 0; trig = 0; dump_done = 0;
      n_total = 2000; n_rb = 8; n_pts = 250; n_acc = 3;
      repeat (3) @(negedge clk);
      n_tests++;
      if (act_vec !== 56'd0) begin n_fail++; $display("FAIL reset_outputs act=%h want 0", act_vec); end
      n_tests++;
      if (act_vec !== exp_vec) begin n_fail++; $display("FAIL reset_model act=%h want %h", act_vec, exp_vec); end
      rst = 0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b want 0", busy); end
   endtask

   task automatic test_acq_sequence();
      int mism = 0, fc = 0, gap, w, first_sv, last_sv, first_dump, sv_cnt, rbl_cnt, rbl_sum;
      bit af, al;
      logic [55:0] fa = '0, fe = '0;
      n_total = 2000; n_rb = 8; n_pts = 250; n_acc = 3; cmd_en = 1;
      for (int p = 0; p < 3; p++) begin
         gap = 100 + int'($urandom_range(0, 500));
         w   = 1 + int'($urandom_range(0, 3));
         first_sv = -1; last_sv = -1; first_dump = -1; sv_cnt = 0; rbl_cnt = 0; rbl_sum = 0;
         af = 0; al = 0;
         for (int i = 0; i < gap + w + 2005; i++) begin
            trig = (i >= gap) && (i < gap + w);
            @(negedge clk);
            if (act_vec !== exp_vec) begin if (mism == 0) begin fc = cyc; fa = act_vec; fe = exp_vec; end mism++; end
            if (sample_valid) begin
               if (first_sv < 0) first_sv = cyc;
               last_sv = cyc; sv_cnt++;
               if (acc_first) af = 1;
               if (acc_last)  al = 1;
            end
            if (rb_last) begin rbl_cnt++; rbl_sum += cyc - first_sv + 1; end
            if (dump_req && first_dump < 0) first_dump = cyc;
         end
         n_tests++;
         if (sv_cnt !== 2000) begin n_fail++; $display("FAIL acq_window_len p=%0d act=%0d want 2000", p, sv_cnt); end
         n_tests++;
         if (rbl_cnt !== 8 || rbl_sum !== 9000) begin
            n_fail++; $display("FAIL acq_rb_last p=%0d count=%0d sum=%0d want 8/9000", p, rbl_cnt, rbl_sum);
         end
         n_tests++;
         if (af !== (p == 0) || al !== (p == 2)) begin
            n_fail++; $display("FAIL acq_first_last p=%0d act=%b%b want %b%b", p, af, al, p == 0, p == 2);
         end
         if (p == 2) begin
            n_tests++;
            if (first_dump - last_sv !== 1) begin
               n_fail++; $display("FAIL acq_dump_rise act=%0d want 1", first_dump - last_sv);
            end
         end
      end
      dump_done = 1;
      @(negedge clk);
      dump_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (act_vec !== exp_vec) begin if (mism == 0) begin fc = cyc; fa = act_vec; fe = exp_vec; end mism++; end
      end
      n_tests++;
      if ({dump_req, busy, pulse_idx} !== {1'b0, 1'b1, 16'd0}) begin
         n_fail++; $display("FAIL acq_after_dump act=%b/%b/%0d want 0/1/0", dump_req, busy, pulse_idx);
      end
      n_tests++;
      if (mism !== 0) begin
         n_fail++; $display("FAIL acq_lockstep count=%0d want 0 first cyc=%0d act=%h want %h", mism, fc, fa, fe);
      end
   endtask

   task automatic test_missed();
      int mism = 0, fc = 0, sv_cnt = 0, exp_missed;
      logic [55:0] fa = '0, fe = '0;
`ifdef ACQ_MISSED_TRIG_CNT_EN
      exp_missed = 1;
`else
      exp_missed = 0;
`endif
      cmd_en = 0; n_total = 2000; n_rb = 8; n_pts = 250; n_acc = 2;
      for (int i = 0; i < 20; i++) begin
         trig = (i >= 3) && (i < 6);
         @(negedge clk);
         if (act_vec !== exp_vec) begin if (mism == 0) begin fc = cyc; fa = act_vec; fe = exp_vec; end mism++; end
         if (sample_valid) sv_cnt++;
      end
      n_tests++;
      if (sv_cnt !== 0 || missed !== 16'd0) begin
         n_fail++; $display("FAIL missed_disabled sv=%0d missed=%0d want 0/0", sv_cnt, missed);
      end
      cmd_en = 1; sv_cnt = 0;
      for (int i = 0; i < 2600; i++) begin
         trig = (i == 5) || (i == 505) || (i == 506);
         @(negedge clk);
         if (act_vec !== exp_vec) begin if (mism == 0) begin fc = cyc; fa = act_vec; fe = exp_vec; end mism++; end
         if (sample_valid) sv_cnt++;
      end
      n_tests++;
      if (sv_cnt !== 2000) begin n_fail++; $display("FAIL missed_window_len act=%0d want 2000", sv_cnt); end
      n_tests++;
      if (missed !== 16'(exp_missed)) begin n_fail++; $display("FAIL missed_count act=%0d want %0d", missed, exp_missed); end
      n_tests++;
      if (mism !== 0) begin
         n_fail++; $display("FAIL missed_lockstep count=%0d want 0 first cyc=%0d act=%h want %h", mism, fc, fa, fe);
      end
   endtask

   task automatic test_cfg_err();
      cmd_en = 0;
      repeat (2) @(negedge clk);
      n_total = 2000; n_rb = 9; n_pts = 250; n_acc = 1; cmd_en = 1;
      repeat (5) @(negedge clk);
      n_tests++;
      if ({cfg_err, busy} !== 2'b10) begin n_fail++; $display("FAIL cfg_err_set act=%b%b want 10", cfg_err, busy); end
      n_rb = 16'hFFFF; n_pts = 16'hFFFF; n_total = 16'hFFFF;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cfg_err, busy} !== 2'b10) begin n_fail++; $display("FAIL cfg_err_wide act=%b%b want 10", cfg_err, busy); end
      n_tests++;
      if (act_vec !== exp_vec) begin n_fail++; $display("FAIL cfg_err_model act=%h want %h", act_vec, exp_vec); end
      n_rb = 8; n_pts = 250; n_total = 2000;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({cfg_err, busy} !== 2'b01) begin n_fail++; $display("FAIL cfg_err_clear act=%b%b want 01", cfg_err, busy); end
   endtask

   task automatic test_unbinned();
      int mism = 0, fc = 0, first_sv = -1, rbv_cnt = 0, last_rbv = 0, dump_cnt = 0;
      bit af = 0, al = 0;
      logic [55:0] fa = '0, fe = '0;
      cmd_en = 0;
      @(negedge clk);
      n_total = 2000; n_rb = 4; n_pts = 250; n_acc = 1; cmd_en = 1; dump_done = 1;
      for (int i = 0; i < 2020; i++) begin
         trig = (i == 4);
         @(negedge clk);
         if (act_vec !== exp_vec) begin if (mism == 0) begin fc = cyc; fa = act_vec; fe = exp_vec; end mism++; end
         if (sample_valid && first_sv < 0) begin first_sv = cyc; af = acc_first; al = acc_last; end
         if (sample_valid && rb_valid) begin rbv_cnt++; last_rbv = cyc - first_sv + 1; end
         if (dump_req) dump_cnt++;
      end
      dump_done = 0;
      n_tests++;
      if (rbv_cnt !== 1000 || last_rbv !== 1000) begin
         n_fail++; $display("FAIL unbinned_rb_valid count=%0d last=%0d want 1000/1000", rbv_cnt, last_rbv);
      end
      n_tests++;
      if ({af, al} !== 2'b11) begin n_fail++; $display("FAIL unbinned_acc1_flags act=%b%b want 11", af, al); end
      n_tests++;
      if (dump_cnt !== 1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL unbinned_dump_once cycles=%0d busy=%b want 1/1", dump_cnt, busy);
      end
      n_tests++;
      if (mism !== 0) begin
         n_fail++; $display("FAIL unbinned_lockstep count=%0d want 0 first cyc=%0d act=%h want %h", mism, fc, fa, fe);
      end
   endtask

   task automatic test_disable_mid();
      bit seen = 0;
      cmd_en = 0;
      @(negedge clk);
      n_total = 300; n_rb = 5; n_pts = 20; n_acc = 3; cmd_en = 1;
      repeat (3) @(negedge clk);
      trig = 1; @(negedge clk); trig = 0;
      repeat (310) @(negedge clk);
      trig = 1; @(negedge clk); trig = 0;
      repeat (100) @(negedge clk);
      n_tests++;
      if (pulse_idx !== 16'd1 || sample_valid !== 1'b1) begin
         n_fail++; $display("FAIL disable_pre pulse=%0d sv=%b want 1/1", pulse_idx, sample_valid);
      end
      cmd_en = 0;
      @(negedge clk);
      n_tests++;
      if (act_vec[55:16] !== 40'd0) begin n_fail++; $display("FAIL disable_idle act=%h want 0", act_vec[55:16]); end
      cmd_en = 1;
      repeat (3) @(negedge clk);
      trig = 1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         trig = 0;
         seen = sample_valid;
      end
      n_tests++;
      if (!seen) begin
         n_fail++; $display("FAIL disable_retrigger_timeout sv=%b want 1", sample_valid);
      end else if (pulse_idx !== 16'd0 || acc_first !== 1'b1) begin
         n_fail++; $display("FAIL disable_restart pulse=%0d acc_first=%b want 0/1", pulse_idx, acc_first);
      end
      repeat (310) @(negedge clk);
   endtask

   task automatic test_random();
      int mism = 0, fc = 0;
      logic [55:0] fa = '0, fe = '0;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) begin
               n_pts   = (r == 0) ? 16'd1 : 16'($urandom_range(1, 8));
               n_rb    = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
               n_total = 16'(int'(n_rb) * int'(n_pts) + int'($urandom_range(0, 10)));
               n_acc   = (r == 1) ? 16'd1 : 16'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 29) == 0) trig = ~trig;
            cmd_en    = ($urandom_range(0, 399) != 0);
            dump_done = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            if (act_vec !== exp_vec) begin if (mism == 0) begin fc = cyc; fa = act_vec; fe = exp_vec; end mism++; end
         end
      end
      trig = 0; dump_done = 0; cmd_en = 1;
      n_tests++;
      if (mism !== 0) begin
         n_fail++; $display("FAIL random_lockstep count=%0d want 0 first cyc=%0d act=%h want %h", mism, fc, fa, fe);
      end
   endtask

   task automatic test_reset_in_dump();
      bit seen = 0;
      cmd_en = 0;
      @(negedge clk);
      n_total = 50; n_rb = 5; n_pts = 10; n_acc = 1; cmd_en = 1;
      repeat (3) @(negedge clk);
      trig = 1; @(negedge clk); trig = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = dump_req;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL rst_dump_timeout dump_req=%b want 1", dump_req); end
      rst = 1; cmd_en = 0;
      @(negedge clk);
      rst = 0;
      n_tests++;
      if (act_vec !== 56'd0) begin n_fail++; $display("FAIL rst_dump_outputs act=%h want 0", act_vec); end
      dump_done = 1; @(negedge clk); dump_done = 0; @(negedge clk);
      n_tests++;
      if (act_vec !== 56'd0 || act_vec !== exp_vec) begin
         n_fail++; $display("FAIL rst_dump_done_ignored act=%h want 0", act_vec);
      end
   endtask

   initial begin
      test_reset();
      test_acq_sequence();
      test_missed();
      test_cfg_err();
      test_unbinned();
      test_disable_mid();
      test_random();
      test_reset_in_dump();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cyc=%0d want finish before 200000", cyc);
      $fatal(1, "timeout");
   end

endmodule
